// File: rtl/slc3_pkg.sv
// slc3_pkg: shared types and constants for the SLC-3 processor.
//   - state_e  : microsequencer states
//   - gate_e   : which source drives the shared bus
//   - aluk_e   : ALU operation select
//   - addr2_e  : offset select for the address adder
//   - ctrl_t   : control word driven by the sequencer into the datapath
//   - sext()   : sign-extend a field whose sign bit sits at position msb
package slc3_pkg;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    typedef enum logic [4:0] {
        StHalted,
        StFetch1,
        StFetch2,
        StFetch3,
        StFetch4,
        StDecode,
        StAlu,
        StBr,
        StJmp,
        StJsr1,
        StJsr2,
        StLdr1,
        StLdr2,
        StLdr3,
        StLdr4,
        StStr1,
        StStr2,
        StStr3,
        StPause1,
        StPause2
    } state_e;

    typedef enum logic [2:0] {
        GateNone,
        GatePc,
        GateMdr,
        GateAlu,
        GateMarmux
    } gate_e;

    typedef enum logic [1:0] {
        AluAdd,
        AluAnd,
        AluNot,
        AluPassA
    } aluk_e;

    typedef enum logic [1:0] {
        Addr2Zero,
        Addr2Off6,
        Addr2Off9,
        Addr2Off11
    } addr2_e;

    // All-zero is the idle control word: nothing loads, bus gated off.
    typedef struct packed {
        logic   ld_mar;
        logic   ld_mdr;
        logic   ld_ir;
        logic   ld_pc;
        logic   ld_reg;
        logic   ld_cc;
        logic   ld_ben;
        logic   ld_led;
        logic   ld_hex;
        logic   mio_en;     // MDR takes read data instead of the bus
        logic   pc_bus;     // PC takes the bus instead of PC+1
        logic   dr_r7;      // destination forced to R7
        logic   sr1_dr;     // SR1 read port uses IR[11:9]
        logic   addr1_base; // address adder base is SR1 instead of PC
        addr2_e addr2;
        aluk_e  aluk;
        gate_e  gate;
    } ctrl_t;

    function automatic logic [15:0] sext(input logic [15:0] val, input logic [3:0] msb);
        logic [15:0] upper;
        upper = 16'hFFFF << msb;
        return val[msb] ? (val | upper) : (val & ~upper);
    endfunction

endpackage

// File: rtl/slc3_if.sv
// slc3_if: external memory bus of the SLC-3.
//   mem_addr  : address (MAR)
//   mem_wdata : write data (MDR)
//   mem_rdata : read data, valid one cycle after mem_addr settles
//   mem_we    : single-cycle write strobe
// master = processor side, slave = memory side.
interface slc3_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_we;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/slc3_datapath.sv
// slc3_datapath: register file, ALU, address adder, bus mux and the
// PC/IR/MAR/MDR/NZP/BEN/LED/hex registers of the SLC-3.
//   clk_i     : clock
//   rst_ni    : synchronous active-low reset
//   ctrl_i    : control word from the sequencer
//   rd_data_i : memory/IO read data (already I/O-mapped)
//   pc_o, ir_o, mar_o, mdr_o : architectural registers
//   ben_o     : registered branch-enable
//   led_o     : PAUSE display, hex_o : last IO store
module slc3_datapath
    import slc3_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  ctrl_t       ctrl_i,
    input  logic [15:0] rd_data_i,
    output logic [15:0] pc_o,
    output logic [15:0] ir_o,
    output logic [15:0] mar_o,
    output logic [15:0] mdr_o,
    output logic        ben_o,
    output logic [11:0] led_o,
    output logic [15:0] hex_o
);

    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];
    logic [2:0]  nzp_q, nzp_d;
    logic        ben_q, ben_d;
    logic [11:0] led_q, led_d;
    logic [15:0] hex_q, hex_d;

    logic [2:0]  sr1_idx, dr_idx;
    logic [15:0] sr1_val, sr2_val, alu_b, alu_out;
    logic [15:0] addr1, addr2, marmux, bus;

    // Operand selection, ALU and address adder.
    always_comb begin
        sr1_idx = ctrl_i.sr1_dr ? ir_q[11:9] : ir_q[8:6];
        dr_idx  = ctrl_i.dr_r7 ? 3'd7 : ir_q[11:9];
        sr1_val = regs_q[sr1_idx];
        sr2_val = regs_q[ir_q[2:0]];
        alu_b   = ir_q[5] ? sext(ir_q, 4'd4) : sr2_val;

        alu_out = sr1_val;
        unique case (ctrl_i.aluk)
            AluAdd:   alu_out = sr1_val + alu_b;
            AluAnd:   alu_out = sr1_val & alu_b;
            AluNot:   alu_out = ~sr1_val;
            AluPassA: alu_out = sr1_val;
            default:  alu_out = sr1_val;
        endcase

        addr1 = ctrl_i.addr1_base ? sr1_val : pc_q;
        addr2 = 16'd0;
        unique case (ctrl_i.addr2)
            Addr2Zero:  addr2 = 16'd0;
            Addr2Off6:  addr2 = sext(ir_q, 4'd5);
            Addr2Off9:  addr2 = sext(ir_q, 4'd8);
            Addr2Off11: addr2 = sext(ir_q, 4'd10);
            default:    addr2 = 16'd0;
        endcase
        marmux = addr1 + addr2;
    end

    // Single shared bus; undriven reads as zero.
    always_comb begin
        bus = 16'd0;
        unique case (ctrl_i.gate)
            GatePc:     bus = pc_q;
            GateMdr:    bus = mdr_q;
            GateAlu:    bus = alu_out;
            GateMarmux: bus = marmux;
            default:    bus = 16'd0;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (ctrl_i.ld_pc) begin
            pc_d = ctrl_i.pc_bus ? bus : pc_q + 16'd1;
        end
        ir_d  = ctrl_i.ld_ir ? bus : ir_q;
        mar_d = ctrl_i.ld_mar ? bus : mar_q;
        mdr_d = mdr_q;
        if (ctrl_i.ld_mdr) begin
            mdr_d = ctrl_i.mio_en ? rd_data_i : bus;
        end

        regs_d = regs_q;
        if (ctrl_i.ld_reg) begin
            regs_d[dr_idx] = bus;
        end

        nzp_d = nzp_q;
        if (ctrl_i.ld_cc) begin
            if (bus[15]) begin
                nzp_d = 3'b100;
            end else if (bus == 16'd0) begin
                nzp_d = 3'b010;
            end else begin
                nzp_d = 3'b001;
            end
        end

        ben_d = ctrl_i.ld_ben ? |(ir_q[11:9] & nzp_q) : ben_q;
        led_d = ctrl_i.ld_led ? ir_q[11:0] : led_q;
        hex_d = ctrl_i.ld_hex ? mdr_q : hex_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q   <= 16'd0;
            ir_q   <= 16'd0;
            mar_q  <= 16'd0;
            mdr_q  <= 16'd0;
            regs_q <= '{default: 16'd0};
            nzp_q  <= 3'b010;
            ben_q  <= 1'b0;
            led_q  <= 12'd0;
            hex_q  <= 16'd0;
        end else begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            mar_q  <= mar_d;
            mdr_q  <= mdr_d;
            regs_q <= regs_d;
            nzp_q  <= nzp_d;
            ben_q  <= ben_d;
            led_q  <= led_d;
            hex_q  <= hex_d;
        end
    end

    assign pc_o  = pc_q;
    assign ir_o  = ir_q;
    assign mar_o = mar_q;
    assign mdr_o = mdr_q;
    assign ben_o = ben_q;
    assign led_o = led_q;
    assign hex_o = hex_q;

endmodule

// File: rtl/slc3_top.sv
// slc3_top: SLC-3 processor top level. Holds the microsequencer (ISDU) and
// the memory-mapped switch/hex I/O; the datapath lives in slc3_datapath.
//   Clk, Reset      : clock, synchronous active-low reset
//   Run, Continue   : active-low start / PAUSE-resume buttons
//   S               : switches, returned by loads from IO_ADDR
//   mem_if          : external memory bus (addr=MAR, wdata=MDR)
//   LED             : IR[11:0] captured by PAUSE
//   hex_out         : last store to IO_ADDR
//   pc_out, ir_out  : debug copies of PC and IR
module slc3_top
    import slc3_pkg::*;
#(
    parameter logic [15:0] IO_ADDR = IO_ADDR_DEFAULT
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Run,
    input  logic          Continue,
    input  logic [15:0]   S,
    slc3_if.master        mem_if,
    output logic [11:0]   LED,
    output logic [15:0]   hex_out,
    output logic [15:0]   pc_out,
    output logic [15:0]   ir_out
);

    state_e      state_q, state_d;
    ctrl_t       ctrl;
    logic        mem_we;
    logic        ben;
    logic [15:0] pc, ir, mar, mdr, rd_data;
    logic [3:0]  opcode;

    assign opcode = ir[15:12];

    // Switches shadow memory at IO_ADDR for every read, fetches included.
    assign rd_data = (mar == IO_ADDR) ? S : mem_if.mem_rdata;

    slc3_datapath u_datapath (
        .clk_i     (Clk),
        .rst_ni    (Reset),
        .ctrl_i    (ctrl),
        .rd_data_i (rd_data),
        .pc_o      (pc),
        .ir_o      (ir),
        .mar_o     (mar),
        .mdr_o     (mdr),
        .ben_o     (ben),
        .led_o     (LED),
        .hex_o     (hex_out)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= StHalted;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        mem_we  = 1'b0;
        unique case (state_q)
            StHalted: begin
                if (!Run) begin
                    state_d = StFetch1;
                end
            end
            StFetch1: begin
                ctrl.gate   = GatePc;
                ctrl.ld_mar = 1'b1;
                ctrl.ld_pc  = 1'b1;
                state_d     = StFetch2;
            end
            StFetch2: state_d = StFetch3;
            StFetch3: begin
                ctrl.ld_mdr = 1'b1;
                ctrl.mio_en = 1'b1;
                state_d     = StFetch4;
            end
            StFetch4: begin
                ctrl.gate  = GateMdr;
                ctrl.ld_ir = 1'b1;
                state_d    = StDecode;
            end
            StDecode: begin
                ctrl.ld_ben = 1'b1;
                case (opcode)
                    OP_ADD, OP_AND, OP_NOT: state_d = StAlu;
                    OP_BR:  state_d = StBr;
                    OP_JMP: state_d = StJmp;
                    OP_JSR: state_d = StJsr1;
                    OP_LDR: state_d = StLdr1;
                    OP_STR: state_d = StStr1;
                    OP_PAUSE: begin
                        // Capture here so LED is already valid while waiting.
                        ctrl.ld_led = 1'b1;
                        state_d     = StPause1;
                    end
                    default: state_d = StFetch1;
                endcase
            end
            StAlu: begin
                ctrl.gate   = GateAlu;
                ctrl.ld_reg = 1'b1;
                ctrl.ld_cc  = 1'b1;
                case (opcode)
                    OP_AND:  ctrl.aluk = AluAnd;
                    OP_NOT:  ctrl.aluk = AluNot;
                    default: ctrl.aluk = AluAdd;
                endcase
                state_d = StFetch1;
            end
            StBr: begin
                if (ben) begin
                    ctrl.gate   = GateMarmux;
                    ctrl.addr2  = Addr2Off9;
                    ctrl.ld_pc  = 1'b1;
                    ctrl.pc_bus = 1'b1;
                end
                state_d = StFetch1;
            end
            StJmp: begin
                ctrl.gate       = GateMarmux;
                ctrl.addr1_base = 1'b1;
                ctrl.addr2      = Addr2Zero;
                ctrl.ld_pc      = 1'b1;
                ctrl.pc_bus     = 1'b1;
                state_d         = StFetch1;
            end
            StJsr1: begin
                ctrl.gate   = GatePc;
                ctrl.dr_r7  = 1'b1;
                ctrl.ld_reg = 1'b1;
                state_d     = StJsr2;
            end
            StJsr2: begin
                ctrl.gate   = GateMarmux;
                ctrl.addr2  = Addr2Off11;
                ctrl.ld_pc  = 1'b1;
                ctrl.pc_bus = 1'b1;
                state_d     = StFetch1;
            end
            StLdr1, StStr1: begin
                ctrl.gate       = GateMarmux;
                ctrl.addr1_base = 1'b1;
                ctrl.addr2      = Addr2Off6;
                ctrl.ld_mar     = 1'b1;
                state_d         = (state_q == StLdr1) ? StLdr2 : StStr2;
            end
            StLdr2: state_d = StLdr3;
            StLdr3: begin
                ctrl.ld_mdr = 1'b1;
                ctrl.mio_en = 1'b1;
                state_d     = StLdr4;
            end
            StLdr4: begin
                ctrl.gate   = GateMdr;
                ctrl.ld_reg = 1'b1;
                ctrl.ld_cc  = 1'b1;
                state_d     = StFetch1;
            end
            StStr2: begin
                // Source register lives in the DR field for stores.
                ctrl.gate   = GateAlu;
                ctrl.sr1_dr = 1'b1;
                ctrl.aluk   = AluPassA;
                ctrl.ld_mdr = 1'b1;
                state_d     = StStr3;
            end
            StStr3: begin
                if (mar == IO_ADDR) begin
                    ctrl.ld_hex = 1'b1;
                end else begin
                    mem_we = 1'b1;
                end
                state_d = StFetch1;
            end
            StPause1: begin
                if (!Continue) begin
                    state_d = StPause2;
                end
            end
            StPause2: begin
                if (Continue) begin
                    state_d = StFetch1;
                end
            end
            default: state_d = StHalted;
        endcase
    end

    assign mem_if.mem_addr  = mar;
    assign mem_if.mem_wdata = mdr;
    assign mem_if.mem_we    = mem_we;
    assign pc_out           = pc;
    assign ir_out           = ir;

endmodule

// File: tb/tb_slc3_top.sv
module tb_slc3_top;
    import slc3_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        cont;
    logic [15:0] sw;
    logic [11:0] led;
    logic [15:0] hex_out, pc_out, ir_out;

    int n_checks = 0;
    int n_pass   = 0;

    slc3_if mem_bus ();

    slc3_top dut (
        .Clk      (clk),
        .Reset    (reset),
        .Run      (run),
        .Continue (cont),
        .S        (sw),
        .mem_if   (mem_bus),
        .LED      (led),
        .hex_out  (hex_out),
        .pc_out   (pc_out),
        .ir_out   (ir_out)
    );

    always #5 clk = ~clk;

    // External memory: registered read, one cycle of latency.
    logic [15:0] dmem [65536];
    always @(posedge clk) begin
        if (mem_bus.mem_we === 1'b1) dmem[mem_bus.mem_addr] <= mem_bus.mem_wdata;
        mem_bus.mem_rdata <= dmem[mem_bus.mem_addr];
    end

    // Instruction-level reference model.
    logic [15:0] m_mem [65536];
    logic [15:0] m_reg [8];
    logic [15:0] m_pc, m_ir, m_hex, m_st_addr;
    logic [11:0] m_led;
    logic [2:0]  m_nzp;
    logic        m_st_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] sx(input logic [15:0] raw, input int bits);
        int v;
        v = int'(raw) % (1 << bits);
        if (v >= (1 << (bits - 1))) v = v - (1 << bits);
        return 16'(v);
    endfunction

    function automatic logic [15:0] m_rd(input logic [15:0] a);
        return (a == 16'hFFFF) ? sw : m_mem[a];
    endfunction

    task automatic set_cc(input logic [15:0] v);
        if (v[15]) m_nzp = 3'b100;
        else if (v == 16'd0) m_nzp = 3'b010;
        else m_nzp = 3'b001;
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_hex = 0; m_led = 0; m_nzp = 3'b010; m_st_valid = 0;
        m_st_addr = 0;
        for (int i = 0; i < 8; i++) m_reg[i] = 0;
    endtask

    task automatic m_step();
        logic [15:0] ir, a, v;
        logic [2:0]  dr, sr1;
        ir = m_rd(m_pc);
        m_ir = ir;
        m_pc = m_pc + 16'd1;
        m_st_valid = 0;
        dr = ir[11:9];
        sr1 = ir[8:6];
        case (ir[15:12])
            4'h1: begin
                v = m_reg[sr1] + (ir[5] ? sx(ir, 5) : m_reg[ir[2:0]]);
                m_reg[dr] = v; set_cc(v);
            end
            4'h5: begin
                v = m_reg[sr1] & (ir[5] ? sx(ir, 5) : m_reg[ir[2:0]]);
                m_reg[dr] = v; set_cc(v);
            end
            4'h9: begin
                v = ~m_reg[sr1];
                m_reg[dr] = v; set_cc(v);
            end
            4'h0: begin
                if ((ir[11] && m_nzp[2]) || (ir[10] && m_nzp[1]) || (ir[9] && m_nzp[0]))
                    m_pc = m_pc + sx(ir, 9);
            end
            4'hC: m_pc = m_reg[sr1];
            4'h4: begin
                m_reg[7] = m_pc;
                m_pc = m_pc + sx(ir, 11);
            end
            4'h6: begin
                a = m_reg[sr1] + sx(ir, 6);
                v = m_rd(a);
                m_reg[dr] = v; set_cc(v);
            end
            4'h7: begin
                a = m_reg[sr1] + sx(ir, 6);
                if (a == 16'hFFFF) m_hex = m_reg[dr];
                else begin
                    m_mem[a] = m_reg[dr];
                    m_st_valid = 1;
                    m_st_addr = a;
                end
            end
            4'hD: m_led = ir[11:0];
            default: ;
        endcase
    endtask

    task automatic compare_arch();
        check("pc", pc_out, m_pc);
        check("ir", ir_out, m_ir);
        for (int i = 0; i < 8; i++)
            check($sformatf("r%0d", i), dut.u_datapath.regs_q[i], m_reg[i]);
        check("nzp", dut.u_datapath.nzp_q, m_nzp);
        check("led", led, m_led);
        check("hex", hex_out, m_hex);
        if (m_st_valid) check("store_mem", dmem[m_st_addr], m_mem[m_st_addr]);
    endtask

    task automatic wait_state(input string tag, input state_e st, input int budget);
        int n = 0;
        while (dut.state_q != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, dut.state_q, st);
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic start_run();
        run = 1'b0;
        @(negedge clk);
        run = 1'b1;
        wait_state("run_start", StFetch1, 5);
    endtask

    // Called at a negedge while in FETCH1; runs one instruction in both
    // model and DUT, handling the Continue handshake for PAUSE.
    task automatic run_instr(input logic [15:0] sw_val);
        int n = 0;
        sw = sw_val;
        m_step();
        @(negedge clk);
        while (dut.state_q != StFetch1 && n < 60) begin
            if (dut.state_q == StPause1 && n >= 6) cont = 1'b0;
            if (dut.state_q == StPause2 && n >= 10) cont = 1'b1;
            @(negedge clk);
            n++;
        end
        cont = 1'b1;
        check("fetch_sync", dut.state_q, StFetch1);
        compare_arch();
    endtask

    initial begin
        logic [15:0] w;
        reset = 1'b0; run = 1'b1; cont = 1'b1; sw = 16'd0;
        for (int a = 0; a < 65536; a++) begin
            dmem[a] = 16'd0;
            m_mem[a] = 16'd0;
        end
        dmem[0]  = 16'h5020; dmem[1]  = 16'h1025; dmem[2]  = 16'h6FF0; dmem[3]  = 16'h03FD;
        dmem[4]  = 16'h5260; dmem[5]  = 16'h127F; dmem[6]  = 16'h6440; dmem[7]  = 16'h7440;
        dmem[8]  = 16'hD0AB; dmem[9]  = 16'h70CA; dmem[11] = 16'h4805; dmem[17] = 16'hC1C0;
        dmem[12] = 16'h983F; dmem[13] = 16'h6AC1; dmem[16'hFFF0] = 16'h1234;
        for (int a = 0; a < 65536; a++) m_mem[a] = dmem[a];

        @(negedge clk);
        reset_dut();
        check("rst_pc", pc_out, 16'd0);
        check("rst_ir", ir_out, 16'd0);
        check("rst_led", led, 12'd0);
        check("rst_hex", hex_out, 16'd0);
        check("rst_state", dut.state_q, StHalted);
        check("rst_we", mem_bus.mem_we, 1'b0);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("halt_pc", pc_out, 16'd0);
        check("halt_state", dut.state_q, StHalted);

        model_reset();
        start_run();
        run_instr(16'd0);
        run_instr(16'd0);
        check("add_r0", dut.u_datapath.regs_q[0], 16'd5);
        check("add_nzp", dut.u_datapath.nzp_q, 3'b001);
        check("add_pc", pc_out, 16'd2);
        run_instr(16'd0);
        check("ldr_r7", dut.u_datapath.regs_q[7], 16'h1234);
        run_instr(16'd0);
        check("brp_taken_pc", pc_out, 16'd1);
        repeat (3) run_instr(16'd0);
        check("brp_not_taken_pc", pc_out, 16'd4);
        check("brp_not_taken_nzp", dut.u_datapath.nzp_q, 3'b010);
        repeat (2) run_instr(16'd0);
        run_instr(16'h000B);
        check("ldr_io_r2", dut.u_datapath.regs_q[2], 16'h000B);
        run_instr(16'd0);
        check("str_io_hex", hex_out, 16'h000B);

        // PAUSE with manual Continue handshake.
        sw = 16'd0;
        m_step();
        wait_state("pause1_reach", StPause1, 20);
        check("pause_led", led, 12'h0AB);
        repeat (5) @(negedge clk);
        check("pause1_hold_pc", pc_out, 16'd9);
        check("pause1_hold_state", dut.state_q, StPause1);
        cont = 1'b0;
        @(negedge clk);
        check("pause2_state", dut.state_q, StPause2);
        repeat (3) @(negedge clk);
        check("pause2_hold_pc", pc_out, 16'd9);
        check("pause2_hold_state", dut.state_q, StPause2);
        cont = 1'b1;
        @(negedge clk);
        check("resume_fetch", dut.state_q, StFetch1);
        compare_arch();

        repeat (5) run_instr(16'd0);
        check("not_r4", dut.u_datapath.regs_q[4], 16'hFFF5);
        check("jsr_r7", dut.u_datapath.regs_q[7], 16'd12);
        check("jmp_pc", pc_out, 16'd13);

        // Reset in the middle of an LDR.
        wait_state("ldr_reach", StLdr2, 20);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_state", dut.state_q, StHalted);
        check("mid_rst_pc", pc_out, 16'd0);
        check("mid_rst_ir", ir_out, 16'd0);
        check("mid_rst_mar", mem_bus.mem_addr, 16'd0);
        check("mid_rst_mdr", mem_bus.mem_wdata, 16'd0);
        check("mid_rst_we", mem_bus.mem_we, 1'b0);
        check("mid_rst_led", led, 12'd0);
        check("mid_rst_hex", hex_out, 16'd0);
        check("mid_rst_nzp", dut.u_datapath.nzp_q, 3'b010);
        for (int i = 0; i < 8; i++)
            check($sformatf("mid_rst_r%0d", i), dut.u_datapath.regs_q[i], 16'd0);

        // Random program: every word of memory is a random instruction.
        for (int a = 0; a < 65536; a++) begin
            w = 16'($urandom);
            dmem[a] = w;
            m_mem[a] = w;
        end
        reset_dut();
        reset = 1'b1;
        model_reset();
        start_run();
        for (int k = 0; k < 400; k++) begin
            run_instr(16'($urandom));
            if (n_checks - n_pass > 20) break;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
